// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, initiator FSM states and the
// exit-decoder address map.
package axi_lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_e;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      WAIT_B,
      READ,
      WAIT_R
   } mst_state_e;

   localparam logic [31:0] EXIT_ADDR      = 32'h0000_0004;
   localparam logic [31:0] EXIT_ZERO_ADDR = 32'h0000_0010;

   // EXOKAY is folded into success; only SLVERR/DECERR report an error.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp == SLVERR) || (resp == DECERR);
   endfunction

endpackage

// File: rtl/obi_axil_master.sv
// Single-outstanding bridge from the core's OBI-style data port to an
// AXI4-Lite manager port; one response pulse per granted request.
module obi_axil_master
   import axi_lite_pkg::*;
#(
   parameter int          ADDR_WIDTH = 32,
   parameter logic [2:0]  AXI_PROT   = 3'b000
) (
   input  logic                  s_axi_aclk,
   input  logic                  s_axi_aresetn,
   input  logic                  req_i,
   output logic                  gnt_o,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic                  we_i,
   input  logic [3:0]            be_i,
   input  logic [31:0]           wdata_i,
   output logic                  rvalid_o,
   output logic [31:0]           rdata_o,
   output logic                  err_o,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [2:0]            m_axi_awprot,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [31:0]           m_axi_wdata,
   output logic [3:0]            m_axi_wstrb,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [31:0]           m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   mst_state_e            state_q, state_d;
   logic                  aw_done_q, w_done_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
   logic [3:0]            wstrb_q;
   logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;

   assign aw_hs = m_axi_awvalid & m_axi_awready;
   assign w_hs  = m_axi_wvalid  & m_axi_wready;
   assign b_hs  = m_axi_bvalid  & m_axi_bready;
   assign ar_hs = m_axi_arvalid & m_axi_arready;
   assign r_hs  = m_axi_rvalid  & m_axi_rready;

   assign m_axi_awaddr = addr_q;
   assign m_axi_araddr = addr_q;
   assign m_axi_wdata  = wdata_q;
   assign m_axi_wstrb  = wstrb_q;
   assign m_axi_awprot = AXI_PROT;
   assign m_axi_arprot = AXI_PROT;

   always_comb begin
      state_d      = state_q;
      gnt_o        = 1'b0;
      m_axi_bready = 1'b0;
      m_axi_rready = 1'b0;
      case (state_q)
         IDLE: begin
            // Gated by reset so gnt_o reads 0 while the bridge is held in reset.
            gnt_o = req_i & s_axi_aresetn;
            if (req_i) state_d = we_i ? WRITE : READ;
         end
         WRITE: begin
            if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = WAIT_B;
         end
         WAIT_B: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) state_d = IDLE;
         end
         READ: begin
            if (ar_hs) state_d = WAIT_R;
         end
         WAIT_R: begin
            m_axi_rready = 1'b1;
            if (m_axi_rvalid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state_q       <= IDLE;
         aw_done_q     <= 1'b0;
         w_done_q      <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         rvalid_o      <= 1'b0;
         rdata_o       <= '0;
         err_o         <= 1'b0;
      end else begin
         state_q  <= state_d;
         rvalid_o <= 1'b0;
         if (gnt_o) begin
            addr_q        <= addr_i;
            wdata_q       <= wdata_i;
            wstrb_q       <= be_i;
            m_axi_awvalid <= we_i;
            m_axi_wvalid  <= we_i;
            m_axi_arvalid <= ~we_i;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
         end
         // AW and W retire independently; either may finish first.
         if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done_q     <= 1'b1;
         end
         if (w_hs) begin
            m_axi_wvalid <= 1'b0;
            w_done_q     <= 1'b1;
         end
         if (ar_hs) m_axi_arvalid <= 1'b0;
         if (b_hs) begin
            rvalid_o <= 1'b1;
            rdata_o  <= '0;
            err_o    <= resp_is_err(m_axi_bresp);
         end
         if (r_hs) begin
            rvalid_o <= 1'b1;
            rdata_o  <= m_axi_rdata;
            err_o    <= resp_is_err(m_axi_rresp);
         end
      end
   end

endmodule

// File: tb/tb_obi_axil_master.sv
// Bench for obi_axil_master: table vectors, randomized transactions against a
// latency/response model, plus back-to-back and mid-transaction reset sequences.
module tb_obi_axil_master;
   import axi_lite_pkg::*;

   logic        s_axi_aclk = 1'b0;
   logic        s_axi_aresetn = 1'b0;
   logic        req_i = 1'b0;
   logic        gnt_o;
   logic [31:0] addr_i = '0;
   logic        we_i = 1'b0;
   logic [3:0]  be_i = '0;
   logic [31:0] wdata_i = '0;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic [31:0] m_axi_awaddr;
   logic [2:0]  m_axi_awprot;
   logic        m_axi_awvalid;
   logic        m_axi_awready = 1'b0;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_wvalid;
   logic        m_axi_wready = 1'b0;
   logic [1:0]  m_axi_bresp = '0;
   logic        m_axi_bvalid = 1'b0;
   logic        m_axi_bready;
   logic [31:0] m_axi_araddr;
   logic [2:0]  m_axi_arprot;
   logic        m_axi_arvalid;
   logic        m_axi_arready = 1'b0;
   logic [31:0] m_axi_rdata = '0;
   logic [1:0]  m_axi_rresp = '0;
   logic        m_axi_rvalid = 1'b0;
   logic        m_axi_rready;

   obi_axil_master #(.ADDR_WIDTH(32), .AXI_PROT(3'b000)) dut (
      .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn),
      .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i), .be_i(be_i),
      .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   always #5 s_axi_aclk = ~s_axi_aclk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          aw_dly;
      int          w_dly;
      int          b_dly;
      int          ar_dly;
      int          r_dly;
      logic [1:0]  resp;
      logic [31:0] rdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[10];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [31:0] all_outputs_or();
      return 32'(|{gnt_o, rvalid_o, rdata_o, err_o, m_axi_awaddr, m_axi_awvalid,
                   m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
                   m_axi_araddr, m_axi_arvalid, m_axi_rready});
   endfunction

   task automatic idle_sub();
      m_axi_awready = 1'b0; m_axi_wready = 1'b0;
      m_axi_bvalid = 1'b0;  m_axi_bresp = '0;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
      m_axi_rresp = '0;     m_axi_rdata = '0;
   endtask

   // One transaction: the subordinate responds after the given delays, the
   // response pulse must land exactly where the latency rules place it.
   task automatic run_txn(input vec_t t, input string tag);
      int c, aw_c, w_c, b_c, ar_c, r_c, pulse_c, exp_lat, bad, busy_gnt;
      logic [31:0] got_rdata;
      logic        got_err;
      aw_c = -1; w_c = -1; b_c = -1; ar_c = -1; r_c = -1; pulse_c = -1;
      bad = 0; busy_gnt = 0; got_rdata = 'x; got_err = 1'bx;
      exp_lat = t.we ? 3 + imax(t.aw_dly, t.w_dly) + t.b_dly : 3 + t.ar_dly + t.r_dly;

      @(negedge s_axi_aclk);
      req_i = 1'b1; we_i = t.we; addr_i = t.addr; be_i = t.be; wdata_i = t.wdata;
      #1 chk({tag, " gnt_idle"}, 32'(gnt_o), 32'd1);
      c = 0;
      while (pulse_c < 0 && c < 80) begin
         @(negedge s_axi_aclk);
         c++;
         if (rvalid_o) begin
            pulse_c = c; got_rdata = rdata_o; got_err = err_o;
         end
         if (t.we) begin
            if (m_axi_awvalid !== (aw_c < 0)) bad++;
            if (m_axi_wvalid !== (w_c < 0)) bad++;
            if (m_axi_awvalid && (m_axi_awaddr !== t.addr || m_axi_awprot !== 3'b000)) bad++;
            if (m_axi_wvalid && (m_axi_wdata !== t.wdata || m_axi_wstrb !== t.be)) bad++;
            if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0) bad++;
            if (m_axi_bready !== (aw_c >= 0 && w_c >= 0 && c > imax(aw_c, w_c) && b_c < 0)) bad++;
         end else begin
            if (m_axi_arvalid !== (ar_c < 0)) bad++;
            if (m_axi_arvalid && (m_axi_araddr !== t.addr || m_axi_arprot !== 3'b000)) bad++;
            if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0 || m_axi_bready !== 1'b0) bad++;
            if (m_axi_rready !== (ar_c >= 0 && c > ar_c && r_c < 0)) bad++;
         end
         // Keep a competing request pending while busy; it must not be granted.
         req_i = (c < exp_lat);
         if (req_i) begin
            we_i = 1'($urandom); addr_i = $urandom; wdata_i = $urandom; be_i = 4'($urandom);
         end
         idle_sub();
         if (t.we) begin
            m_axi_awready = (aw_c < 0) && (c >= 1 + t.aw_dly);
            m_axi_wready  = (w_c < 0) && (c >= 1 + t.w_dly);
            m_axi_bvalid  = (aw_c >= 0) && (w_c >= 0) && (b_c < 0) &&
                            (c >= imax(aw_c, w_c) + 1 + t.b_dly);
            m_axi_bresp   = m_axi_bvalid ? t.resp : 2'b00;
         end else begin
            m_axi_arready = (ar_c < 0) && (c >= 1 + t.ar_dly);
            m_axi_rvalid  = (ar_c >= 0) && (r_c < 0) && (c >= ar_c + 1 + t.r_dly);
            m_axi_rresp   = m_axi_rvalid ? t.resp : 2'b00;
            m_axi_rdata   = m_axi_rvalid ? t.rdata : $urandom;
         end
         #1 if (gnt_o) busy_gnt++;
         if (m_axi_awvalid && m_axi_awready) aw_c = c;
         if (m_axi_wvalid && m_axi_wready) w_c = c;
         if (m_axi_bvalid && m_axi_bready) b_c = c;
         if (m_axi_arvalid && m_axi_arready) ar_c = c;
         if (m_axi_rvalid && m_axi_rready) r_c = c;
      end
      req_i = 1'b0;
      idle_sub();
      chk({tag, " latency"}, 32'(pulse_c), 32'(exp_lat));
      chk({tag, " rdata"}, got_rdata, t.exp_rdata);
      chk({tag, " err"}, 32'(got_err), 32'(t.exp_err));
      chk({tag, " protocol"}, 32'(bad), 32'd0);
      chk({tag, " gnt_busy"}, 32'(busy_gnt), 32'd0);
      @(negedge s_axi_aclk);
      chk({tag, " single_pulse"}, 32'(rvalid_o), 32'd0);
   endtask

   initial begin
      vec_t r;
      int   pulses;

      // we addr be wdata | aw w b ar r dly | resp rdata | exp_err exp_rdata
      vecs[0] = '{1'b1, EXIT_ADDR,      4'hF, 32'h0,        0, 0, 0, 0, 0, OKAY,   32'h0,        1'b0, 32'h0};
      vecs[1] = '{1'b1, EXIT_ZERO_ADDR, 4'hF, 32'h1,        2, 0, 0, 0, 0, OKAY,   32'h0,        1'b0, 32'h0};
      vecs[2] = '{1'b1, 32'h20,         4'h3, 32'hA5A5_0001, 0, 2, 1, 0, 0, OKAY,   32'h0,        1'b0, 32'h0};
      vecs[3] = '{1'b1, 32'h24,         4'hC, 32'h1234_5678, 2, 2, 0, 0, 0, EXOKAY, 32'h0,        1'b0, 32'h0};
      vecs[4] = '{1'b0, 32'h8,          4'hF, 32'h0,        0, 0, 0, 0, 2, OKAY,   32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
      vecs[5] = '{1'b1, 32'h30,         4'hF, 32'hCAFE_F00D, 0, 0, 0, 0, 0, SLVERR, 32'h0,        1'b1, 32'h0};
      vecs[6] = '{1'b0, 32'h34,         4'hF, 32'h0,        0, 0, 0, 0, 0, DECERR, 32'h1234_5678, 1'b1, 32'h1234_5678};
      vecs[7] = '{1'b0, 32'h38,         4'hF, 32'h0,        0, 0, 0, 1, 0, EXOKAY, 32'h0BAD_CAFE, 1'b0, 32'h0BAD_CAFE};
      vecs[8] = '{1'b1, 32'h3C,         4'h1, 32'h0000_00FF, 1, 3, 2, 0, 0, DECERR, 32'h0,        1'b1, 32'h0};
      vecs[9] = '{1'b0, 32'h40,         4'hF, 32'h0,        0, 0, 0, 3, 1, OKAY,   32'h8000_0001, 1'b0, 32'h8000_0001};

      // Reset state, with a request pending to show gnt_o is held low.
      req_i = 1'b1;
      repeat (3) @(negedge s_axi_aclk);
      #1 chk("reset_outputs", all_outputs_or(), 32'd0);
      req_i = 1'b0;
      s_axi_aresetn = 1'b1;

      for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 40; i++) begin
         r.we = 1'($urandom); r.addr = {$urandom} & 32'hFFFF_FFFC; r.be = 4'($urandom);
         r.wdata = $urandom; r.rdata = $urandom; r.resp = 2'($urandom);
         r.aw_dly = $urandom_range(0, 3); r.w_dly = $urandom_range(0, 3);
         r.b_dly = $urandom_range(0, 3);  r.ar_dly = $urandom_range(0, 3);
         r.r_dly = $urandom_range(0, 3);
         r.exp_err = (r.resp >= 2'd2);
         r.exp_rdata = r.we ? 32'h0 : r.rdata;
         run_txn(r, $sformatf("rnd%0d", i));
      end

      // Back-to-back writes with req_i held high and an always-ready subordinate.
      @(negedge s_axi_aclk);
      req_i = 1'b1; we_i = 1'b1; addr_i = EXIT_ADDR; wdata_i = 32'h0; be_i = 4'hF;
      m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1; m_axi_bresp = OKAY;
      #1 chk("b2b gnt0", 32'(gnt_o), 32'd1);
      @(negedge s_axi_aclk);
      addr_i = EXIT_ZERO_ADDR; wdata_i = 32'h1; be_i = 4'h3;
      #1 chk("b2b c1 gnt", 32'(gnt_o), 32'd0);
      chk("b2b c1 awvalid", 32'(m_axi_awvalid), 32'd1);
      chk("b2b c1 awaddr", m_axi_awaddr, EXIT_ADDR);
      @(negedge s_axi_aclk);
      chk("b2b c2 bready", 32'(m_axi_bready), 32'd1);
      chk("b2b c2 awvalid", 32'(m_axi_awvalid), 32'd0);
      @(negedge s_axi_aclk);
      chk("b2b c3 rvalid", 32'(rvalid_o), 32'd1);
      chk("b2b c3 awvalid", 32'(m_axi_awvalid), 32'd0);
      #1 chk("b2b c3 gnt", 32'(gnt_o), 32'd1);
      @(negedge s_axi_aclk);
      req_i = 1'b0;
      chk("b2b c4 awvalid", 32'(m_axi_awvalid), 32'd1);
      chk("b2b c4 awaddr", m_axi_awaddr, EXIT_ZERO_ADDR);
      chk("b2b c4 wstrb", 32'(m_axi_wstrb), 32'h3);
      chk("b2b c4 rvalid", 32'(rvalid_o), 32'd0);
      repeat (2) @(negedge s_axi_aclk);
      chk("b2b c6 rvalid", 32'(rvalid_o), 32'd1);
      chk("b2b c6 err", 32'(err_o), 32'd0);
      idle_sub();
      @(negedge s_axi_aclk);

      // Reset while awvalid is stalled on a low awready.
      @(negedge s_axi_aclk);
      req_i = 1'b1; we_i = 1'b1; addr_i = EXIT_ZERO_ADDR; wdata_i = 32'h1; be_i = 4'hF;
      @(negedge s_axi_aclk);
      req_i = 1'b0;
      chk("rst pre awvalid", 32'(m_axi_awvalid), 32'd1);
      #2 s_axi_aresetn = 1'b0;
      req_i = 1'b1;
      #1 chk("rst outputs", all_outputs_or(), 32'd0);
      pulses = 0;
      repeat (3) begin
         @(negedge s_axi_aclk);
         if (rvalid_o) pulses++;
      end
      chk("rst no rvalid", 32'(pulses), 32'd0);
      req_i = 1'b0;
      s_axi_aresetn = 1'b1;
      run_txn(vecs[0], "post_rst_wr");
      run_txn(vecs[4], "post_rst_rd");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
